// File: rtl/run_ctrl_pkg.sv
// run_ctrl_pkg
//   Definitions shared by the pipeline run/step sequencer:
//   - STATE_W          : width of the state encoding exported on state_o
//   - state_t          : sequencer states with their fixed encodings
//   - CLEAR_CYCLES_DEF : default length of the latch flush, in cycles
package run_ctrl_pkg;

  localparam int STATE_W          = 3;
  localparam int CLEAR_CYCLES_DEF = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_PAUSE = 3'd2,
    ST_RUN   = 3'd3,
    ST_STEP  = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

endpackage

// File: rtl/sat_counter.sv
// sat_counter
//   Up-counter that sticks at all-ones instead of wrapping.
//   Ports:
//     clk   in   clock, updates on posedge
//     rst_n in   asynchronous active-low reset (q -> 0)
//     clr   in   synchronous clear, wins over inc
//     inc   in   add one unless already saturated
//     q     out  W-bit count
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc && (q != '1)) begin
      q <= q + 1'b1;
    end
  end

endmodule

// File: rtl/pipeline_run_ctrl.sv
// pipeline_run_ctrl
//   Run/step sequencer for the five-stage pipeline. Drives the common stage
//   latch enable (activo) and synchronous latch clear (inicio), and halts when
//   the end-of-program marker finalW reaches writeback.
//   The state register updates on posedge; the pipeline latches sample on
//   negedge, so a command sampled at posedge k takes effect at the latch
//   negedge inside cycle k. All outputs are Moore, decoded from state.
//   Ports:
//     clk         in   pipeline clock
//     inicio_n    in   asynchronous active-low reset
//     cmd_start   in   flush pipeline, then pause
//     cmd_run     in   start or continue free-running
//     cmd_pause   in   stop after the current cycle
//     cmd_step    in   advance exactly one clock
//     finalW      in   end-of-program flag from the MEM/WB latch
//     activo      out  latch enable to all pipeline latches
//     inicio      out  synchronous clear to all pipeline latches
//     running     out  high in RUN
//     done        out  high in DONE
//     state_o     out  current state encoding (debug)
//     cycle_count out  enabled cycles executed since the last flush
//   Optional breakpoint (macro RUN_CTRL_BREAKPOINT_EN) adds:
//     pcF, bp_addr, bp_en in; bp_hit out (sticky)
//   Command priority: cmd_start > finalW > breakpoint > cmd_pause > cmd_run
//   > cmd_step.
module pipeline_run_ctrl
  import run_ctrl_pkg::*;
#(
  parameter int CLEAR_CYCLES = CLEAR_CYCLES_DEF,
  parameter int CNT_W        = 32
) (
  input  logic               clk,
  input  logic               inicio_n,
  input  logic               cmd_start,
  input  logic               cmd_run,
  input  logic               cmd_pause,
  input  logic               cmd_step,
  input  logic               finalW,
`ifdef RUN_CTRL_BREAKPOINT_EN
  input  logic [31:0]        pcF,
  input  logic [31:0]        bp_addr,
  input  logic               bp_en,
  output logic               bp_hit,
`endif
  output logic               activo,
  output logic               inicio,
  output logic               running,
  output logic               done,
  output logic [STATE_W-1:0] state_o,
  output logic [CNT_W-1:0]   cycle_count
);

  // CLEAR lasts CLEAR_CYCLES cycles: the down-counter is loaded with N-1 and
  // the last flush cycle is the one in which it reads zero.
  localparam logic [3:0] CLR_LOAD = 4'(CLEAR_CYCLES - 1);

  state_t     state, next_state;
  logic [3:0] clr_cnt;
  logic       bp_match;

`ifdef RUN_CTRL_BREAKPOINT_EN
  assign bp_match = bp_en && (pcF == bp_addr);
`else
  assign bp_match = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge inicio_n) begin
    if (!inicio_n) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic. cmd_start leads to CLEAR from every state, including
  // CLEAR itself where it restarts the flush count.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (cmd_start) next_state = ST_CLEAR;
      end
      ST_CLEAR: begin
        if (cmd_start)            next_state = ST_CLEAR;
        else if (clr_cnt == 4'd0) next_state = ST_PAUSE;
      end
      ST_PAUSE: begin
        if (cmd_start)      next_state = ST_CLEAR;
        else if (cmd_pause) next_state = ST_PAUSE;
        else if (cmd_run)   next_state = ST_RUN;
        else if (cmd_step)  next_state = ST_STEP;
      end
      ST_RUN: begin
        if (cmd_start)      next_state = ST_CLEAR;
        else if (finalW)    next_state = ST_DONE;
        else if (bp_match)  next_state = ST_PAUSE;
        else if (cmd_pause) next_state = ST_PAUSE;
      end
      ST_STEP: begin
        // Breakpoint deliberately ignored so the user can step off it.
        if (cmd_start)   next_state = ST_CLEAR;
        else if (finalW) next_state = ST_DONE;
        else             next_state = ST_PAUSE;
      end
      ST_DONE: begin
        if (cmd_start) next_state = ST_CLEAR;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Flush-length down-counter; reloaded on every cmd_start since that is
  // always an entry (or re-entry) into CLEAR.
  always_ff @(posedge clk or negedge inicio_n) begin
    if (!inicio_n) begin
      clr_cnt <= 4'd0;
    end else if (cmd_start) begin
      clr_cnt <= CLR_LOAD;
    end else if ((state == ST_CLEAR) && (clr_cnt != 4'd0)) begin
      clr_cnt <= clr_cnt - 4'd1;
    end
  end

  // Moore output decode
  always_comb begin
    activo  = 1'b0;
    inicio  = 1'b0;
    running = 1'b0;
    done    = 1'b0;
    case (state)
      ST_CLEAR: begin
        activo = 1'b1;
        inicio = 1'b1;
      end
      ST_RUN: begin
        activo  = 1'b1;
        running = 1'b1;
      end
      ST_STEP: activo = 1'b1;
      ST_DONE: done   = 1'b1;
      default: ;
    endcase
  end

  assign state_o = state;

  // Every cycle spent in RUN or STEP had activo high, so it is counted at the
  // posedge that closes it. Clearing on cmd_start zeroes the count on the
  // same edge that enters CLEAR.
  sat_counter #(
    .W (CNT_W)
  ) u_cycle_cnt (
    .clk   (clk),
    .rst_n (inicio_n),
    .clr   (cmd_start),
    .inc   ((state == ST_RUN) || (state == ST_STEP)),
    .q     (cycle_count)
  );

`ifdef RUN_CTRL_BREAKPOINT_EN
  // Sticky breakpoint flag: set on the edge that leaves RUN because of the
  // breakpoint, cleared by the next run/step/start command.
  always_ff @(posedge clk or negedge inicio_n) begin
    if (!inicio_n) begin
      bp_hit <= 1'b0;
    end else if ((state == ST_RUN) && !cmd_start && !finalW && bp_match) begin
      bp_hit <= 1'b1;
    end else if (cmd_run || cmd_step || cmd_start) begin
      bp_hit <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_run_ctrl.sv
// tb_pipeline_run_ctrl
//   Directed bench for pipeline_run_ctrl. Expected status words are derived
//   from the state encodings and Moore output table, queued when a step is
//   driven and popped once the clock edge has produced the DUT response.
//   Build with RUN_CTRL_BREAKPOINT_EN defined to include the breakpoint test.
module tb_pipeline_run_ctrl;

  logic        clk;
  logic        inicio_n;
  logic        cmd_start, cmd_run, cmd_pause, cmd_step, finalW;
  logic        activo, inicio, running, done;
  logic [2:0]  state_o;
  logic [31:0] cycle_count;
`ifdef RUN_CTRL_BREAKPOINT_EN
  logic [31:0] pcF, bp_addr;
  logic        bp_en, bp_hit;
`endif

  int checks = 0;
  int errors = 0;
  int act_cnt = 0;
  int act_base;

  logic [31:0] exp_q[$];

  localparam logic [2:0] S_IDLE = 3'd0, S_CLEAR = 3'd1, S_PAUSE = 3'd2,
                         S_RUN  = 3'd3, S_STEP  = 3'd4, S_DONE  = 3'd5;

  pipeline_run_ctrl #(
    .CLEAR_CYCLES (2),
    .CNT_W        (32)
  ) dut (
    .clk         (clk),
    .inicio_n    (inicio_n),
    .cmd_start   (cmd_start),
    .cmd_run     (cmd_run),
    .cmd_pause   (cmd_pause),
    .cmd_step    (cmd_step),
    .finalW      (finalW),
`ifdef RUN_CTRL_BREAKPOINT_EN
    .pcF         (pcF),
    .bp_addr     (bp_addr),
    .bp_en       (bp_en),
    .bp_hit      (bp_hit),
`endif
    .activo      (activo),
    .inicio      (inicio),
    .running     (running),
    .done        (done),
    .state_o     (state_o),
    .cycle_count (cycle_count)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Latch-side view: count negedges on which the latches were enabled.
  always @(negedge clk) if (activo) act_cnt++;

  // {state, activo, inicio, running, done} expected for a given state
  function automatic logic [31:0] stat(input logic [2:0] s);
    logic [3:0] o;
    case (s)
      S_CLEAR: o = 4'b1100;
      S_RUN:   o = 4'b1010;
      S_STEP:  o = 4'b1000;
      S_DONE:  o = 4'b0001;
      default: o = 4'b0000;
    endcase
    return {25'd0, s, o};
  endfunction

  function automatic logic [31:0] dut_stat();
    return {25'd0, state_o, activo, inicio, running, done};
  endfunction

  task automatic check_one(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL %s: scoreboard empty, observed %0h", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        errors++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, e);
      end
    end
  endtask

  // Pop and compare status word then cycle_count
  task automatic check_pair(input string tag);
    check_one({tag, ".status"}, dut_stat());
    check_one({tag, ".count"}, cycle_count);
  endtask

  // Driver: advance one clock, sample 1ns after the active edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Queue the expected outcome of the next edge, clock it, compare
  task automatic step_exp(input string tag, input logic [2:0] s,
                          input logic [31:0] cnt);
    exp_q.push_back(stat(s));
    exp_q.push_back(cnt);
    tick();
    check_pair(tag);
  endtask

  task automatic clear_cmds();
    cmd_start = 0; cmd_run = 0; cmd_pause = 0; cmd_step = 0; finalW = 0;
  endtask

  initial begin
    clear_cmds();
    inicio_n = 1'b0;
`ifdef RUN_CTRL_BREAKPOINT_EN
    pcF = 32'h0; bp_addr = 32'h40; bp_en = 1'b0;
`endif
    #12;
    // Reset state
    exp_q.push_back(stat(S_IDLE));
    exp_q.push_back(32'd0);
    check_pair("reset");
    @(negedge clk);
    inicio_n = 1'b1;
    tick();

    // IDLE ignores everything but cmd_start
    cmd_run = 1; cmd_step = 1;
    step_exp("idle_ignore", S_IDLE, 0);
    clear_cmds();

    // 1. Flush for two cycles, then PAUSE
    cmd_start = 1;
    step_exp("clear1", S_CLEAR, 0);
    cmd_start = 0;
    step_exp("clear2", S_CLEAR, 0);
    step_exp("pause_after_clear", S_PAUSE, 0);

    // 2. Free run for 10 cycles, finalW seen in the 10th
    cmd_run = 1;
    step_exp("run_enter", S_RUN, 0);
    cmd_run = 0;
    for (int i = 1; i <= 9; i++) step_exp("run_cyc", S_RUN, i);
    finalW = 1;
    step_exp("run_final", S_DONE, 10);
    finalW = 0;
    cmd_run = 1; cmd_step = 1;
    step_exp("done_hold", S_DONE, 10);
    clear_cmds();

    // 3. Single steps from a fresh flush
    cmd_start = 1;
    step_exp("reflush1", S_CLEAR, 0);
    cmd_start = 0;
    step_exp("reflush2", S_CLEAR, 0);
    step_exp("reflush_pause", S_PAUSE, 0);
    act_base = act_cnt;
    for (int i = 0; i < 3; i++) begin
      cmd_step = 1;
      step_exp("step_pulse", S_STEP, i);
      cmd_step = 0;
      step_exp("step_back", S_PAUSE, i + 1);
      step_exp("step_idle", S_PAUSE, i + 1);
    end
    exp_q.push_back(32'd3);
    check_one("step_activo_clocks", act_cnt - act_base);
    // Held cmd_step alternates STEP and PAUSE
    cmd_step = 1;
    step_exp("held_step1", S_STEP, 3);
    step_exp("held_pause1", S_PAUSE, 4);
    step_exp("held_step2", S_STEP, 4);
    step_exp("held_pause2", S_PAUSE, 5);
    cmd_step = 0;
    // cmd_pause outranks cmd_run in PAUSE
    cmd_pause = 1; cmd_run = 1;
    step_exp("pause_over_run", S_PAUSE, 5);
    clear_cmds();

    // 4. finalW and cmd_pause together in RUN -> DONE
    cmd_run = 1;
    step_exp("run4_enter", S_RUN, 5);
    cmd_run = 0;
    step_exp("run4_cyc", S_RUN, 6);
    cmd_pause = 1; finalW = 1;
    step_exp("final_over_pause", S_DONE, 7);
    clear_cmds();

    // 5. Mid-run flush at cycle_count=7
    cmd_start = 1;
    step_exp("fl_clear1", S_CLEAR, 0);
    cmd_start = 0;
    step_exp("fl_clear2", S_CLEAR, 0);
    step_exp("fl_pause", S_PAUSE, 0);
    cmd_run = 1;
    step_exp("fl_run", S_RUN, 0);
    cmd_run = 0;
    for (int i = 1; i <= 7; i++) step_exp("fl_run_cyc", S_RUN, i);
    cmd_start = 1;
    step_exp("midrun_start", S_CLEAR, 0);
    cmd_start = 0;
    step_exp("midrun_clear2", S_CLEAR, 0);
    // cmd_start inside CLEAR restarts the two-cycle count
    cmd_start = 1;
    step_exp("restart_clear1", S_CLEAR, 0);
    cmd_start = 0;
    step_exp("restart_clear2", S_CLEAR, 0);
    step_exp("restart_pause", S_PAUSE, 0);
    // plain cmd_pause in RUN
    cmd_run = 1;
    step_exp("p_run", S_RUN, 0);
    cmd_run = 0; cmd_pause = 1;
    step_exp("p_pause", S_PAUSE, 1);
    clear_cmds();
    // Async reset in the middle of CLEAR
    cmd_start = 1;
    step_exp("ar_clear", S_CLEAR, 0);
    cmd_start = 0;
    #2;
    inicio_n = 1'b0;
    #1;
    exp_q.push_back(stat(S_IDLE));
    exp_q.push_back(32'd0);
    check_pair("async_reset");
    @(negedge clk);
    inicio_n = 1'b1;
    step_exp("after_reset", S_IDLE, 0);

`ifdef RUN_CTRL_BREAKPOINT_EN
    // 6. Breakpoint at 0x40
    cmd_start = 1;
    step_exp("bp_clear1", S_CLEAR, 0);
    cmd_start = 0;
    step_exp("bp_clear2", S_CLEAR, 0);
    step_exp("bp_pause", S_PAUSE, 0);
    bp_en = 1; bp_addr = 32'h40; pcF = 32'h3c;
    cmd_run = 1;
    step_exp("bp_run", S_RUN, 0);
    cmd_run = 0;
    step_exp("bp_run_cyc", S_RUN, 1);
    pcF = 32'h40;
    step_exp("bp_stop", S_PAUSE, 2);
    exp_q.push_back(32'd1);
    check_one("bp_hit_set", {31'd0, bp_hit});
    cmd_step = 1;
    step_exp("bp_step", S_STEP, 2);
    cmd_step = 0;
    exp_q.push_back(32'd0);
    check_one("bp_hit_clr", {31'd0, bp_hit});
    step_exp("bp_step_back", S_PAUSE, 3);
    bp_en = 0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_run_ctrl.md
Name: pipeline_run_ctrl

Overview:
- Run/step sequencer for the five-stage MIPS pipeline.
- Drives the common `activo` (stage-latch enable) and `inicio` (synchronous latch clear) into every inter-stage latch, including the MEM/WB latch.
- Halts the pipeline when the end-of-program marker `finalW` reaches writeback.
- Supports continuous run, pause and single-cycle step for the debug unit.

Parameters:
- CLEAR_CYCLES, 2, number of cycles `inicio` and `activo` are held high to flush all latches (range 1..15).
- CNT_W, 32, width of the executed-cycle counter.

Ports:
- clk  in  1  pipeline clock. The controller updates on posedge; the latches sample on negedge.
- inicio_n  in  1  reset, asynchronous, active-low.
- cmd_start  in  1  flush pipeline and enter pause, ready to run.
- cmd_run  in  1  start or continue free-running.
- cmd_pause  in  1  stop after the current cycle.
- cmd_step  in  1  advance exactly one clock.
- finalW  in  1  end-of-program flag from the MEM/WB latch output.
- activo  out  1  latch enable to all pipeline latches.
- inicio  out  1  synchronous clear to all pipeline latches, active-high.
- running  out  1  high in RUN.
- done  out  1  high in DONE.
- state_o  out  3  current state encoding.
- cycle_count  out  CNT_W  number of enabled cycles executed since the last flush.

Behaviour:
- Reset (inicio_n=0, async): state=IDLE; activo=0, inicio=0, running=0, done=0, cycle_count=0.
- Outputs are Moore, decoded from the state register.
  - The state updates on posedge clk, so activo and inicio are stable before the following negedge.
  - A command sampled at posedge k affects the latch negedge within cycle k.
- States and encodings:
  - IDLE=0
  - CLEAR=1, with activo=1, inicio=1
  - PAUSE=2
  - RUN=3, with activo=1
  - STEP=4, with activo=1
  - DONE=5
- Command priority when several are high: cmd_start > finalW > cmd_pause > cmd_run > cmd_step.
- IDLE: cmd_start -> CLEAR. All other commands are ignored.
- CLEAR: lasts exactly CLEAR_CYCLES cycles (internal 4-bit down-counter), then -> PAUSE. Commands other than cmd_start are ignored. cmd_start restarts the count.
- PAUSE:
  - cmd_run -> RUN.
  - cmd_step -> STEP.
  - cmd_pause has no effect.
- RUN:
  - Each cycle, cycle_count += 1.
  - finalW=1 -> DONE. No further activo cycle is issued after finalW is observed.
  - cmd_pause -> PAUSE.
  - finalW together with cmd_pause -> DONE.
- STEP:
  - Exactly one cycle with activo=1; cycle_count += 1.
  - Next state is PAUSE, or DONE if finalW=1.
  - cmd_step held high produces one enabled cycle every two clocks (STEP, PAUSE, STEP, ...).
- DONE: activo=0, done=1. cmd_start -> CLEAR. Other commands are ignored.
- cmd_start in any non-IDLE state -> CLEAR. This is the mid-run flush.
- cycle_count:
  - Cleared on entry to CLEAR.
  - Saturates at all-ones and never wraps.
- finalW is only acted on in RUN and STEP. It is a don't-care elsewhere, because CLEAR zeroes it in the latches.

Optional Feature:
- Macro: RUN_CTRL_BREAKPOINT_EN.
- When defined:
  - Adds ports `pcF` (in, 32), `bp_addr` (in, 32), `bp_en` (in, 1) and `bp_hit` (out, 1, sticky).
  - In RUN, if bp_en=1 and pcF==bp_addr, the controller goes -> PAUSE at the same posedge and sets bp_hit=1.
  - bp_hit clears on the next cmd_run, cmd_step or cmd_start, and on reset.
  - Breakpoint priority sits between finalW and cmd_pause.
  - STEP ignores the breakpoint, so the user can step off it.
- When undefined: the ports are absent and RUN stops only on finalW or cmd_pause.

Decomposition:
- Shared package `run_ctrl_pkg`:
  - State encoding constants (IDLE..DONE).
  - 3-bit state width constant.
  - CLEAR_CYCLES default.
- Sub-module `sat_counter` (parameter W; clr, inc, q; saturating) holds cycle_count.

Test Plan:
1. Reset, then cmd_start: CLEAR for 2 cycles with activo=1 and inicio=1, then PAUSE with activo=0 and cycle_count=0.
2. PAUSE, then cmd_run, then finalW raised after 10 RUN cycles: the DONE transition occurs on the posedge where finalW is first sampled high; cycle_count=10; activo=0 thereafter; done=1.
3. PAUSE, then three separate cmd_step pulses: exactly 3 activo-high clocks, cycle_count=3; held cmd_step alternates STEP and PAUSE.
4. RUN with cmd_pause and finalW high in the same cycle: the next state is DONE, not PAUSE.
5. cmd_start mid-RUN at cycle_count=7: CLEAR, and cycle_count reads 0 on the next cycle. Separately, inicio_n low mid-CLEAR: immediate IDLE with all outputs 0.
6. With RUN_CTRL_BREAKPOINT_EN, bp_addr=0x40, pcF reaches 0x40 in RUN: PAUSE and bp_hit=1; cmd_step advances one cycle and clears bp_hit.
